// File: rtl/tone_player.sv
// Score sequencer plus square-wave tone generator driven from clockin.
// Optional feature macro: TONE_PLAYER_LOOP_EN (score wraps to address 0 instead of finishing).
module tone_player #(
  parameter int CLK_HZ     = 1000000,
  parameter int ADDR_WIDTH = 5,
  parameter int TONE_WIDTH = 11
) (
  input  logic                  clockin,
  input  logic                  reset,
  input  logic                  beat_in,
  input  logic                  start,
  input  logic                  stop,
  output logic                  speaker,
  output logic [3:0]            note_code,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  // Score is 16 notes long; the upper half of the address space repeats it.
  function automatic logic [3:0] rom_note(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd1;
      4'd2:    code = 4'd5;
      4'd3:    code = 4'd5;
      4'd4:    code = 4'd6;
      4'd5:    code = 4'd6;
      4'd6:    code = 4'd5;
      4'd7:    code = 4'd0;
      4'd8:    code = 4'd4;
      4'd9:    code = 4'd4;
      4'd10:   code = 4'd3;
      4'd11:   code = 4'd3;
      4'd12:   code = 4'd2;
      4'd13:   code = 4'd2;
      4'd14:   code = 4'd1;
      4'd15:   code = 4'd0;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  function automatic logic [TONE_WIDTH-1:0] half_period(input logic [3:0] code);
    logic [TONE_WIDTH-1:0] hp;
    case (code)
      4'd1:    hp = TONE_WIDTH'(CLK_HZ / (2 * 262));
      4'd2:    hp = TONE_WIDTH'(CLK_HZ / (2 * 294));
      4'd3:    hp = TONE_WIDTH'(CLK_HZ / (2 * 330));
      4'd4:    hp = TONE_WIDTH'(CLK_HZ / (2 * 349));
      4'd5:    hp = TONE_WIDTH'(CLK_HZ / (2 * 392));
      4'd6:    hp = TONE_WIDTH'(CLK_HZ / (2 * 440));
      4'd7:    hp = TONE_WIDTH'(CLK_HZ / (2 * 494));
      4'd8:    hp = TONE_WIDTH'(CLK_HZ / (2 * 523));
      4'd9:    hp = TONE_WIDTH'(CLK_HZ / (2 * 587));
      4'd10:   hp = TONE_WIDTH'(CLK_HZ / (2 * 659));
      4'd11:   hp = TONE_WIDTH'(CLK_HZ / (2 * 698));
      4'd12:   hp = TONE_WIDTH'(CLK_HZ / (2 * 784));
      4'd13:   hp = TONE_WIDTH'(CLK_HZ / (2 * 880));
      4'd14:   hp = TONE_WIDTH'(CLK_HZ / (2 * 988));
      4'd15:   hp = TONE_WIDTH'(CLK_HZ / (2 * 1047));
      default: hp = {TONE_WIDTH{1'b0}};
    endcase
    return hp;
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [TONE_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    spk_q, spk_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    beat_tick_s;
  logic                    restart_s;
  logic [3:0]              note_cur_s;
  logic [3:0]              note_nxt_s;
  logic                    note_change_s;
  logic [TONE_WIDTH-1:0]   half_s;

  // Beat synchroniser and rising-edge detect.
  always_comb begin
    s1_d        = beat_in;
    s2_d        = s1_q;
    s3_d        = s2_q;
    beat_tick_s = s2_q & ~s3_q;
  end

  // Sequencer next state: stop beats start, start beats a beat tick.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    restart_s = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d   = PLAY;
      addr_d    = {ADDR_WIDTH{1'b0}};
      restart_s = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        PLAY: begin
          if (beat_tick_s) begin
            if (addr_q == LAST_ADDR) begin
`ifdef TONE_PLAYER_LOOP_EN
              addr_d = {ADDR_WIDTH{1'b0}};
`else
              state_d = DONE;
`endif
            end else begin
              addr_d = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
          end else begin
            state_d = PLAY;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d == PLAY);
    done_d = (state_d == DONE);
  end

  // Current and upcoming note codes; any difference restarts the tone phase.
  always_comb begin
    if (state_q == PLAY) begin
      note_cur_s = rom_note(addr_q[3:0]);
    end else begin
      note_cur_s = 4'd0;
    end
    if (state_d == PLAY) begin
      note_nxt_s = rom_note(addr_d[3:0]);
    end else begin
      note_nxt_s = 4'd0;
    end
    note_change_s = restart_s | (state_d != state_q) | (addr_d != addr_q) |
                    (note_nxt_s != note_cur_s);
    half_s        = half_period(note_cur_s);
  end

  // Tone counter: toggles the speaker every half-period of the current note.
  always_comb begin
    cnt_d = cnt_q;
    spk_d = spk_q;
    if (note_change_s) begin
      cnt_d = {TONE_WIDTH{1'b0}};
      spk_d = 1'b0;
    end else if (note_cur_s == 4'd0) begin
      cnt_d = {TONE_WIDTH{1'b0}};
      spk_d = 1'b0;
    end else if (cnt_q == (half_s - {{(TONE_WIDTH-1){1'b0}}, 1'b1})) begin
      cnt_d = {TONE_WIDTH{1'b0}};
      spk_d = ~spk_q;
    end else begin
      cnt_d = cnt_q + {{(TONE_WIDTH-1){1'b0}}, 1'b1};
      spk_d = spk_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clockin) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      cnt_q   <= {TONE_WIDTH{1'b0}};
      spk_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      cnt_q   <= cnt_d;
      spk_q   <= spk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign speaker   = spk_q;
  assign note_code = note_cur_s;
  assign addr      = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_tone_player.sv
// Directed self-checking bench for tone_player at default parameters.
module tb_tone_player;

  logic       clockin;
  logic       reset;
  logic       beat_in;
  logic       start;
  logic       stop;
  logic       speaker;
  logic [3:0] note_code;
  logic [4:0] addr;
  logic       busy;
  logic       done;

  int errors;
  int checks;
  int n;
  logic hi_seen;

  tone_player dut (
    .clockin   (clockin),
    .reset     (reset),
    .beat_in   (beat_in),
    .start     (start),
    .stop      (stop),
    .speaker   (speaker),
    .note_code (note_code),
    .addr      (addr),
    .busy      (busy),
    .done      (done)
  );

  initial clockin = 1'b0;
  always #5 clockin = ~clockin;

  task automatic step();
    @(posedge clockin);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat_pulse(input int hi, input int lo);
    beat_in = 1'b1;
    repeat (hi) step();
    beat_in = 1'b0;
    repeat (lo) step();
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_speaker"}, speaker, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_note"}, note_code, 0);
    chk({tag, "_addr"}, addr, 0);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset   = 1'b1;
    beat_in = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;

    // Reset held for 3 cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      start   = 1'($urandom_range(0, 1));
      stop    = 1'($urandom_range(0, 1));
      beat_in = 1'($urandom_range(0, 1));
      step();
      idle_outputs("reset_hold");
    end
    reset   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    beat_in = 1'b0;
    repeat (3) step();
    idle_outputs("reset_after");

    // Start with no beats: note 1, half-period 1908.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_addr", addr, 0);
    chk("start_note", note_code, 1);
    chk("start_spk", speaker, 0);
    repeat (1907) step();
    chk("tone1_before_rise", speaker, 0);
    step();
    chk("tone1_rise", speaker, 1);
    repeat (1907) step();
    chk("tone1_before_fall", speaker, 1);
    step();
    chk("tone1_fall", speaker, 0);

    // Beat latency: addr moves on the 3rd edge after beat_in is sampled high.
    beat_in = 1'b1;
    step();
    step();
    chk("beat_edge2_addr", addr, 0);
    step();
    chk("beat_edge3_addr", addr, 1);
    repeat (5) step();
    chk("beat_hold_addr", addr, 1);
    beat_in = 1'b0;
    repeat (10) step();
    chk("beat_fall_addr", addr, 1);

    beat_pulse(6, 6);
    chk("addr2", addr, 2);
    chk("addr2_note", note_code, 5);
    n = 0;
    while (speaker == 1'b1 && n < 5000) begin step(); n++; end
    n = 0;
    while (speaker == 1'b0 && n < 5000) begin step(); n++; end
    n = 0;
    while (speaker == 1'b1 && n < 5000) begin step(); n++; end
    chk("addr2_half", n, 1275);

    // Rest note at addr 7 keeps the speaker low.
    repeat (5) beat_pulse(6, 6);
    chk("addr7", addr, 7);
    chk("addr7_note", note_code, 0);
    hi_seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (speaker) hi_seen = 1'b1;
    end
    chk("rest_speaker", hi_seen, 0);

    // Priority: stop wins over start, addr holds.
    repeat (2) beat_pulse(6, 6);
    chk("addr9", addr, 9);
    chk("addr9_note", note_code, 4);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", busy, 0);
    chk("startstop_addr", addr, 9);
    chk("startstop_note", note_code, 0);
    chk("startstop_done", done, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_addr", addr, 0);
    chk("restart_busy", busy, 1);

    // Start coincident with a beat tick discards the tick.
    beat_in = 1'b1;
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_tick_addr", addr, 0);
    repeat (4) step();
    chk("start_tick_later", addr, 0);
    beat_in = 1'b0;
    repeat (6) step();

    // Reset mid-note at addr 4 with speaker high.
    repeat (4) beat_pulse(6, 6);
    chk("addr4", addr, 4);
    n = 0;
    while (speaker == 1'b0 && n < 3000) begin step(); n++; end
    chk("addr4_spk_high", speaker, 1);
    reset = 1'b1;
    step();
    idle_outputs("midreset");
    step();
    chk("midreset_done2", done, 0);
    reset = 1'b0;
    repeat (2) step();

    // End of score.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (31) beat_pulse(3, 3);
    chk("addr31", addr, 31);
    chk("addr31_busy", busy, 1);
    beat_in = 1'b1;
    step();
    step();
    step();
`ifdef TONE_PLAYER_LOOP_EN
    chk("loop_addr", addr, 0);
    chk("loop_busy", busy, 1);
    chk("loop_done", done, 0);
    step();
    chk("loop_done2", done, 0);
    chk("loop_busy2", busy, 1);
`else
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_addr", addr, 31);
    chk("end_spk", speaker, 0);
    chk("end_note", note_code, 0);
    step();
    chk("end_done_clear", done, 0);
    chk("end_busy2", busy, 0);
    chk("end_addr2", addr, 31);
`endif
    beat_in = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_player.md
# tone_player

Score sequencer and square-wave tone generator for the music demo. Consumes the beat clock produced by the fixed integer clock divider. Each rising beat edge advances through an internal 32-entry note ROM. Drives the speaker pin with a square wave at the current note's pitch, derived directly from `clockin`.

## Interface

Parameters:
- `CLK_HZ`, 1000000, `clockin` frequency in Hz; sets the tone half-period table.
- `ADDR_WIDTH`, 5, score address width; score length is 2^ADDR_WIDTH = 32.
- `TONE_WIDTH`, 11, tone counter width; must hold the largest half-period (1908 at default).

Ports:
- `clockin` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `beat_in` in 1: beat clock from the divider, treated as asynchronous level.
- `start` in 1: one-cycle pulse; begins playback at address 0.
- `stop` in 1: one-cycle pulse; aborts playback.
- `speaker` out 1: square-wave audio output.
- `note_code` out 4: current note; 0 = rest.
- `addr` out ADDR_WIDTH: current score address.
- `busy` out 1: high while in PLAY.
- `done` out 1: one-cycle pulse at end of score.

## Operation

- **Beat sync:** `beat_in` passes through two flops (s1, s2), then a third (s3). `beat_tick` = s2 & ~s3.
- **FSM states:** IDLE, PLAY, DONE.
  - IDLE --start--> PLAY, with `addr` set to 0.
  - In PLAY, each `beat_tick` increments `addr`.
  - A tick at `addr` == 31 goes to DONE (see Configuration).
  - DONE lasts one cycle (`done`=1), then IDLE.
  - `stop` in any state goes to IDLE; `addr` holds its value.
- **Priority:** reset > stop > start > beat_tick.
  - `start` while in PLAY restarts at `addr` 0.
  - A tick in the same cycle as `start` is discarded.
- **Score ROM**, indexed by `addr`:
  - Entries 0-15: 1,1,5,5,6,6,5,0,4,4,3,3,2,2,1,0.
  - Entries 16-31 repeat entries 0-15.
- **`note_code`** = ROM[`addr`] when in PLAY, else 0. It is combinational from registers.
- **Tone table:** half-period = CLK_HZ/(2*f), integer division.
  - Codes 1-7 map to 262, 294, 330, 349, 392, 440, 494 Hz.
  - Codes 8-14 map to 523, 587, 659, 698, 784, 880, 988 Hz.
  - Code 15 maps to 1047 Hz.
  - Default half-periods: code 1 = 1908, code 5 = 1275, code 6 = 1136.
- **Tone counter**, updated every cycle, first matching rule wins:
  - If `note_code` changed this edge (addr change, start, or leaving PLAY): counter=0, `speaker`=0.
  - Else if `note_code` == 0: counter=0, `speaker`=0.
  - Else if counter == half-1: counter=0 and `speaker` toggles.
  - Else: counter+1.
- **Counter arithmetic:** unsigned TONE_WIDTH-bit; never exceeds half-1.

## Timing

- **Reset values:**
  - `speaker`=0, `addr`=0, `busy`=0, `done`=0, `note_code`=0.
  - FSM=IDLE, counter=0, s1/s2/s3=0.
- **Start latency:** the edge that samples `start` sets `busy`=1 and `addr`=0. `note_code` is valid in the following cycle.
- **Beat latency:** `addr` increments on the 3rd `clockin` rising edge after `beat_in` is first sampled high. There is one increment per beat rising edge; falling edges are ignored.
- **Tone timing:** the first `speaker` rise comes `half` cycles after the note change. Period = 2*half cycles; duty is exactly 50%.
- **Reset mid-play:** all state returns to reset values on the next edge; no `done` pulse.
- **`done`:** high for exactly one cycle, in the cycle after the terminating tick. `busy` is 0 in that same cycle.

## Configuration

- **`TONE_PLAYER_LOOP_EN`**
  - Defined: a tick at `addr` 31 wraps `addr` to 0 and stays in PLAY. `done` never asserts; `busy` stays 1.
  - Undefined: a tick at `addr` 31 goes to DONE, pulses `done`, then IDLE. `addr` stays 31 and `speaker`=0.

## Test plan

- **Reset:** hold `reset` high for 3 cycles with random inputs. Expect `speaker`/`busy`/`done`/`note_code`=0 and `addr`=0 throughout and after release.
- **Start, no beats:** pulse `start`. Expect `busy`=1 and `note_code`=1; `speaker` rises 1908 cycles after the note change and toggles every 1908 cycles.
- **Beat stepping:** toggle `beat_in` every 5000 cycles. Expect `addr` 0→1→2 on the 3rd edge after each rise. At `addr` 2, `note_code`=5 with half-period 1275. At `addr` 7, `note_code`=0 with `speaker` held at 0.
- **End of score, macro off:** after 32 beat rises, expect a `done` one-cycle pulse, `busy`=0, `addr`=31, `speaker`=0. With `TONE_PLAYER_LOOP_EN`: `addr` wraps 31→0, no `done`, `busy`=1.
- **Priority:**
  - At `addr` 9, assert `start` and `stop` together. Expect IDLE with `addr`=9.
  - Then `start` alone. Expect `addr`=0 and `busy`=1.
  - `start` coincident with `beat_tick`. Expect `addr`=0, not 1.
- **Reset mid-note:** assert `reset` at `addr` 4 with `speaker`=1. Next edge, all outputs are at reset values and no `done` pulse occurs.
